// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: FSM state encodings, register constants
// and the default (no-hazard) pipeline control word.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MD_DRAIN = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write_en;
    logic if_id_write_en;
    logic id_ex_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic muldiv_start;
  } hazard_ctrl_t;

  // Pipeline free-running: every stage loads, nothing is squashed.
  localparam hazard_ctrl_t CTRL_IDLE = '{
    pc_write_en:    1'b1,
    if_id_write_en: 1'b1,
    id_ex_hold:     1'b0,
    if_id_flush:    1'b0,
    id_ex_flush:    1'b0,
    ex_mem_bubble:  1'b0,
    muldiv_start:   1'b0
  };

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return mem_read && (rd != REG_X0) &&
           ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit. With HAZARD_STATS_EN defined the
// stall/flush/muldiv statistics outputs are added.
interface hazard_stall_unit_if
`ifdef HAZARD_STATS_EN
  #(parameter int STAT_W = 32)
`endif
  ;
  logic [4:0] rs1_label_if_id_o;
  logic [4:0] rs2_label_if_id_o;
  logic       rs1_used_i;
  logic       rs2_used_i;
  logic [4:0] rd_label_id_ex_o;
  logic       mem_read_id_ex_o;
  logic       muldiv_id_ex_o;
  logic       muldiv_done_i;
  logic       branch_taken_ex_i;
  logic       pc_write_en_o;
  logic       if_id_write_en_o;
  logic       id_ex_hold_o;
  logic       if_id_flush_o;
  logic       id_ex_flush_o;
  logic       ex_mem_bubble_o;
  logic       muldiv_start_o;
  logic       muldiv_timeout_o;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_o;
  logic [STAT_W-1:0] flush_events_o;
  logic [STAT_W-1:0] muldiv_cycles_o;
`endif

  // Hazard unit side.
  modport master (
    input  rs1_label_if_id_o, rs2_label_if_id_o, rs1_used_i, rs2_used_i,
           rd_label_id_ex_o, mem_read_id_ex_o, muldiv_id_ex_o, muldiv_done_i,
           branch_taken_ex_i,
    output pc_write_en_o, if_id_write_en_o, id_ex_hold_o, if_id_flush_o,
           id_ex_flush_o, ex_mem_bubble_o, muldiv_start_o, muldiv_timeout_o
`ifdef HAZARD_STATS_EN
    , output stall_cycles_o, flush_events_o, muldiv_cycles_o
`endif
  );

  // Pipeline side.
  modport slave (
    output rs1_label_if_id_o, rs2_label_if_id_o, rs1_used_i, rs2_used_i,
           rd_label_id_ex_o, mem_read_id_ex_o, muldiv_id_ex_o, muldiv_done_i,
           branch_taken_ex_i,
    input  pc_write_en_o, if_id_write_en_o, id_ex_hold_o, if_id_flush_o,
           id_ex_flush_o, ex_mem_bubble_o, muldiv_start_o, muldiv_timeout_o
`ifdef HAZARD_STATS_EN
    , input stall_cycles_o, flush_events_o, muldiv_cycles_o
`endif
  );

endinterface

// File: rtl/hazard_stall_unit_stats_counters.sv
// Saturating stall/flush/muldiv-busy event counters; only built with HAZARD_STATS_EN.
`ifdef HAZARD_STATS_EN
module hazard_stats_counters #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_s,
  input  logic              flush_s,
  input  logic              md_busy_s,
  output logic [STAT_W-1:0] stall_cycles_o,
  output logic [STAT_W-1:0] flush_events_o,
  output logic [STAT_W-1:0] muldiv_cycles_o
);

  logic [STAT_W-1:0] stall_cnt_r;
  logic [STAT_W-1:0] flush_cnt_r;
  logic [STAT_W-1:0] md_cnt_r;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
      md_cnt_r    <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != '1)) stall_cnt_r <= stall_cnt_r + STAT_W'(1);
      if (flush_s && (flush_cnt_r != '1)) flush_cnt_r <= flush_cnt_r + STAT_W'(1);
      if (md_busy_s && (md_cnt_r != '1))  md_cnt_r    <= md_cnt_r + STAT_W'(1);
    end
  end

  assign stall_cycles_o  = stall_cnt_r;
  assign flush_events_o  = flush_cnt_r;
  assign muldiv_cycles_o = md_cnt_r;

endmodule
`endif

// File: rtl/hazard_stall_unit.sv
// Stall/flush decision for load-use, multi-cycle muldiv and taken branches.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_unit_if.master hz
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_e         state_r;
  md_state_e         state_nxt_s;
  logic [CNT_W-1:0]  md_cnt_r;
  logic [CNT_W-1:0]  md_cnt_nxt_s;
  logic              timeout_r;
  logic              set_timeout_s;
  logic              load_use_s;
  hazard_ctrl_t      ctrl_s;

  assign load_use_s = load_use_hit(hz.mem_read_id_ex_o, hz.rd_label_id_ex_o,
                                   hz.rs1_label_if_id_o, hz.rs1_used_i,
                                   hz.rs2_label_if_id_o, hz.rs2_used_i);

  // State, busy-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      md_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      md_cnt_r  <= md_cnt_nxt_s;
      timeout_r <= timeout_r | set_timeout_s;
    end
  end

  // Next state and pipeline controls; reset cycle forces the idle control word.
  always_comb begin
    ctrl_s        = CTRL_IDLE;
    state_nxt_s   = state_r;
    md_cnt_nxt_s  = md_cnt_r;
    set_timeout_s = 1'b0;
    if (rst) begin
      state_nxt_s  = ST_RUN;
      md_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz.muldiv_id_ex_o) begin
            ctrl_s.pc_write_en    = 1'b0;
            ctrl_s.if_id_write_en = 1'b0;
            ctrl_s.id_ex_hold     = 1'b1;
            ctrl_s.ex_mem_bubble  = 1'b1;
            ctrl_s.muldiv_start   = 1'b1;
            state_nxt_s           = ST_MD_BUSY;
            md_cnt_nxt_s          = '0;
          end else if (hz.branch_taken_ex_i) begin
            // The dependant in ID is wrong-path, so load-use is moot here.
            ctrl_s.if_id_flush = 1'b1;
            ctrl_s.id_ex_flush = 1'b1;
          end else if (load_use_s) begin
            ctrl_s.pc_write_en    = 1'b0;
            ctrl_s.if_id_write_en = 1'b0;
            ctrl_s.id_ex_flush    = 1'b1;
          end else begin
            ctrl_s = CTRL_IDLE;
          end
        end
        ST_MD_BUSY: begin
          if (hz.muldiv_done_i) begin
            state_nxt_s  = ST_RUN;
            md_cnt_nxt_s = '0;
          end else if (md_cnt_r == CNT_LAST) begin
            ctrl_s.ex_mem_bubble = 1'b1;
            set_timeout_s        = 1'b1;
            state_nxt_s          = ST_MD_DRAIN;
            md_cnt_nxt_s         = '0;
          end else begin
            ctrl_s.pc_write_en    = 1'b0;
            ctrl_s.if_id_write_en = 1'b0;
            ctrl_s.id_ex_hold     = 1'b1;
            ctrl_s.ex_mem_bubble  = 1'b1;
            md_cnt_nxt_s          = md_cnt_r + CNT_W'(1);
          end
        end
        ST_MD_DRAIN: begin
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s  = ST_RUN;
          md_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  assign hz.pc_write_en_o    = ctrl_s.pc_write_en;
  assign hz.if_id_write_en_o = ctrl_s.if_id_write_en;
  assign hz.id_ex_hold_o     = ctrl_s.id_ex_hold;
  assign hz.if_id_flush_o    = ctrl_s.if_id_flush;
  assign hz.id_ex_flush_o    = ctrl_s.id_ex_flush;
  assign hz.ex_mem_bubble_o  = ctrl_s.ex_mem_bubble;
  assign hz.muldiv_start_o   = ctrl_s.muldiv_start;
  assign hz.muldiv_timeout_o = timeout_r;

`ifdef HAZARD_STATS_EN
  hazard_stats_counters #(.STAT_W(STAT_W)) u_stats (
    .clk             (clk),
    .rst             (rst),
    .stall_s         (~ctrl_s.pc_write_en),
    .flush_s         (ctrl_s.if_id_flush),
    .md_busy_s       ((state_r == ST_MD_BUSY) && !rst),
    .stall_cycles_o  (hz.stall_cycles_o),
    .flush_events_o  (hz.flush_events_o),
    .muldiv_cycles_o (hz.muldiv_cycles_o)
  );
`endif

endmodule
